// File: rtl/lsu_align_if.sv
// rtl/lsu_align_if.sv - EX/MEM request, data memory port and writeback bundle for lsu_align
// misalign is present only when LSU_MISALIGN_TRAP_EN is defined.
interface lsu_align_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            ex_valid;
  logic            ex_re;
  logic            ex_we;
  logic [1:0]      ex_size;
  logic            ex_unsigned;
  logic [XLEN-1:0] ex_addr;
  logic [XLEN-1:0] ex_wdata;
  logic [RD_W-1:0] ex_rd;

  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_write_data;
  logic [XLEN-1:0] mem_read_data;

  logic            lsu_stall;
  logic            wb_valid;
  logic            wb_load_en;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_load_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic            misalign;
`endif

  modport slave (
    input  ex_valid, ex_re, ex_we, ex_size, ex_unsigned, ex_addr, ex_wdata, ex_rd,
    input  mem_read_data,
    output mem_we, mem_addr, mem_write_data,
    output lsu_stall, wb_valid, wb_load_en, wb_rd, wb_load_data
`ifdef LSU_MISALIGN_TRAP_EN
    , output misalign
`endif
  );

  modport master (
    output ex_valid, ex_re, ex_we, ex_size, ex_unsigned, ex_addr, ex_wdata, ex_rd,
    output mem_read_data,
    input  mem_we, mem_addr, mem_write_data,
    input  lsu_stall, wb_valid, wb_load_en, wb_rd, wb_load_data
`ifdef LSU_MISALIGN_TRAP_EN
    , input misalign
`endif
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store alignment unit: load extension, sub-word store RMW with stall
// LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of forcing natural alignment.
module lsu_align #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  lsu_align_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE,
    RMW_WR
  } state_t;

  state_t          state, state_next, cur_state;
  logic [XLEN-1:0] saved_addr, saved_word;
  logic [XLEN-1:0] aligned_addr, merged_word, load_ext;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;
  logic            size_byte, size_half, misaligned;
  logic            is_store, is_load, save_rmw, retire;
  logic            mem_we_c, stall_c;
  logic [XLEN-1:0] mem_addr_c, mem_wdata_c;

  logic            wb_valid_q, wb_load_en_q;
  logic [RD_W-1:0] wb_rd_q;
  logic [XLEN-1:0] wb_load_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic            misalign_q;
`endif

  always_comb begin
    size_byte    = (bus.ex_size == 2'b00);
    size_half    = (bus.ex_size == 2'b01);
    is_store     = bus.ex_valid & bus.ex_we;
    is_load      = bus.ex_valid & bus.ex_re & ~bus.ex_we;
    aligned_addr = {bus.ex_addr[XLEN-1:2], 2'b00};
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = (size_half & bus.ex_addr[0]) |
                 (~size_byte & ~size_half & (bus.ex_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  // Store lane merge into the word currently held in memory.
  always_comb begin
    merged_word = bus.mem_read_data;
    if (size_byte) begin
      case (bus.ex_addr[1:0])
        2'd0:    merged_word[7:0]   = bus.ex_wdata[7:0];
        2'd1:    merged_word[15:8]  = bus.ex_wdata[7:0];
        2'd2:    merged_word[23:16] = bus.ex_wdata[7:0];
        default: merged_word[31:24] = bus.ex_wdata[7:0];
      endcase
    end else if (bus.ex_addr[1]) begin
      merged_word[31:16] = bus.ex_wdata[15:0];
    end else begin
      merged_word[15:0] = bus.ex_wdata[15:0];
    end
  end

  always_comb begin
    case (bus.ex_addr[1:0])
      2'd0:    byte_val = bus.mem_read_data[7:0];
      2'd1:    byte_val = bus.mem_read_data[15:8];
      2'd2:    byte_val = bus.mem_read_data[23:16];
      default: byte_val = bus.mem_read_data[31:24];
    endcase
    half_val = bus.ex_addr[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    if (size_byte) begin
      load_ext = {{24{~bus.ex_unsigned & byte_val[7]}}, byte_val};
    end else if (size_half) begin
      load_ext = {{16{~bus.ex_unsigned & half_val[15]}}, half_val};
    end else begin
      load_ext = bus.mem_read_data;
    end
  end

  // During reset the outputs are evaluated as if already in IDLE.
  assign cur_state = rst ? IDLE : state;

  always_comb begin
    state_next  = cur_state;
    mem_we_c    = 1'b0;
    mem_addr_c  = aligned_addr;
    mem_wdata_c = bus.ex_wdata;
    stall_c     = 1'b0;
    save_rmw    = 1'b0;
    case (cur_state)
      IDLE: begin
        if (is_store && !misaligned) begin
          if (size_byte || size_half) begin
            stall_c    = 1'b1;
            save_rmw   = 1'b1;
            state_next = RMW_WR;
          end else begin
            mem_we_c = 1'b1;
          end
        end
      end
      RMW_WR: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = saved_addr;
        mem_wdata_c = saved_word;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      mem_we_c = 1'b0;
    end
  end

  assign retire = bus.ex_valid & ~stall_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      saved_addr     <= '0;
      saved_word     <= '0;
      wb_valid_q     <= 1'b0;
      wb_load_en_q   <= 1'b0;
      wb_rd_q        <= '0;
      wb_load_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q     <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      wb_valid_q   <= retire;
      wb_load_en_q <= retire & is_load & ~misaligned;
      if (save_rmw) begin
        saved_addr <= aligned_addr;
        saved_word <= merged_word;
      end
      if (retire) begin
        wb_rd_q <= bus.ex_rd;
      end
      if (retire && is_load) begin
        wb_load_data_q <= load_ext;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= retire & misaligned & (is_load | is_store) & (cur_state == IDLE);
`endif
    end
  end

  assign bus.mem_we         = mem_we_c;
  assign bus.mem_addr       = mem_addr_c;
  assign bus.mem_write_data = mem_wdata_c;
  assign bus.lsu_stall      = stall_c;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_load_en     = wb_load_en_q;
  assign bus.wb_rd          = wb_rd_q;
  assign bus.wb_load_data   = wb_load_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.misalign       = misalign_q;
`endif

endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - directed self-checking bench for lsu_align with a word memory model
module tb_lsu_align;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] mem [0:1023];

  lsu_align_if bus ();

  lsu_align dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic req(input logic v, input logic re, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [4:0] rd);
    @(negedge clk);
    bus.ex_valid    = v;
    bus.ex_re       = re;
    bus.ex_we       = we;
    bus.ex_size     = size;
    bus.ex_unsigned = uns;
    bus.ex_addr     = addr;
    bus.ex_wdata    = wdata;
    bus.ex_rd       = rd;
    #1;
  endtask

  task automatic load_and_check(input string tag, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [4:0] rd,
                                input logic [31:0] exp);
    req(1'b1, 1'b1, 1'b0, size, uns, addr, 32'h0, rd);
    check({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, bus.wb_valid}, 32'd1);
    check({tag, "_load_en"}, {31'd0, bus.wb_load_en}, 32'd1);
    check({tag, "_rd"}, {27'd0, bus.wb_rd}, {27'd0, rd});
    check({tag, "_data"}, bus.wb_load_data, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h104 >> 2] = 32'h11223344;
    mem[32'h108 >> 2] = 32'hCAFEF00D;
    mem[32'h200 >> 2] = 32'h8000FF80;
    mem[32'h20C >> 2] = 32'h0;

    // Word store presented while reset is high must not reach memory.
    rst = 1'b1;
    req(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h55555555, 5'd3);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_wb_load_en", {31'd0, bus.wb_load_en}, 32'd0);
    check("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    check("rst_wb_data", bus.wb_load_data, 32'd0);
    check("rst_mem_untouched", mem[32'h100 >> 2], 32'h0);

    req(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store then read back.
    req(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd1);
    check("sw_we", {31'd0, bus.mem_we}, 32'd1);
    check("sw_addr", bus.mem_addr, 32'h100);
    check("sw_data", bus.mem_write_data, 32'hDEADBEEF);
    check("sw_stall", {31'd0, bus.lsu_stall}, 32'd0);
    @(posedge clk); #1;
    check("sw_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("sw_wb_load_en", {31'd0, bus.wb_load_en}, 32'd0);
    load_and_check("lw_100", 2'b10, 1'b0, 32'h100, 5'd5, 32'hDEADBEEF);

    // SB into lane 2: two-cycle read-modify-write.
    req(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h106, 32'hFFFFFFAB, 5'd7);
    check("sb_c1_stall", {31'd0, bus.lsu_stall}, 32'd1);
    check("sb_c1_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk); #1;
    check("sb_stall_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("sb_stall_wb_rd_hold", {27'd0, bus.wb_rd}, 32'd5);
    check("sb_stall_wb_data_hold", bus.wb_load_data, 32'hDEADBEEF);
    check("sb_c2_we", {31'd0, bus.mem_we}, 32'd1);
    check("sb_c2_stall", {31'd0, bus.lsu_stall}, 32'd0);
    check("sb_c2_addr", bus.mem_addr, 32'h104);
    check("sb_c2_data", bus.mem_write_data, 32'h11AB3344);
    @(posedge clk); #1;
    check("sb_retire_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("sb_retire_load_en", {31'd0, bus.wb_load_en}, 32'd0);
    check("sb_retire_rd", {27'd0, bus.wb_rd}, 32'd7);
    load_and_check("lw_104", 2'b10, 1'b0, 32'h104, 5'd6, 32'h11AB3344);

    // Sub-word load extension.
    load_and_check("lb_200", 2'b00, 1'b0, 32'h200, 5'd8, 32'hFFFFFF80);
    load_and_check("lbu_200", 2'b00, 1'b1, 32'h200, 5'd9, 32'h00000080);
    load_and_check("lh_202", 2'b01, 1'b0, 32'h202, 5'd10, 32'hFFFF8000);
    load_and_check("lhu_202", 2'b01, 1'b1, 32'h202, 5'd11, 32'h00008000);
    load_and_check("lb_201", 2'b00, 1'b0, 32'h201, 5'd12, 32'hFFFFFFFF);
    load_and_check("lbu_203", 2'b00, 1'b1, 32'h203, 5'd13, 32'h00000080);
    load_and_check("lw_size3", 2'b11, 1'b0, 32'h200, 5'd14, 32'h8000FF80);

    // Idle cycle: no retire, data and rd hold.
    req(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd20);
    check("idle_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk); #1;
    check("idle_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("idle_load_en", {31'd0, bus.wb_load_en}, 32'd0);
    check("idle_data_hold", bus.wb_load_data, 32'h8000FF80);
    check("idle_rd_hold", {27'd0, bus.wb_rd}, 32'd14);

    // re and we both high behave as a store.
    req(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20C, 32'hA5A5A5A5, 5'd15);
    check("rewe_we", {31'd0, bus.mem_we}, 32'd1);
    @(posedge clk); #1;
    check("rewe_load_en", {31'd0, bus.wb_load_en}, 32'd0);
    check("rewe_mem", mem[32'h20C >> 2], 32'hA5A5A5A5);

    // Reset during the RMW write cycle of an SH aborts the write.
    req(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h10A, 32'h00001234, 5'd16);
    check("sh_rst_c1_stall", {31'd0, bus.lsu_stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("sh_rst_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk); #1;
    check("sh_rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("sh_rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    check("sh_rst_wb_data", bus.wb_load_data, 32'd0);
    check("sh_rst_mem", mem[32'h108 >> 2], 32'hCAFEF00D);
    req(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    load_and_check("lw_108_after_rst", 2'b10, 1'b0, 32'h108, 5'd17, 32'hCAFEF00D);

    // SH to the upper half completes normally.
    req(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h10A, 32'hFFFF1234, 5'd18);
    check("sh_c1_stall", {31'd0, bus.lsu_stall}, 32'd1);
    @(posedge clk); #1;
    check("sh_c2_data", bus.mem_write_data, 32'h1234F00D);
    @(posedge clk); #1;
    load_and_check("lw_108", 2'b10, 1'b0, 32'h108, 5'd19, 32'h1234F00D);

    // Misaligned word store.
    req(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h102, 32'h0BADF00D, 5'd21);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_sw_we", {31'd0, bus.mem_we}, 32'd0);
    check("mis_sw_stall", {31'd0, bus.lsu_stall}, 32'd0);
    @(posedge clk); #1;
    check("mis_sw_flag", {31'd0, bus.misalign}, 32'd1);
    check("mis_sw_valid", {31'd0, bus.wb_valid}, 32'd1);
    load_and_check("lw_100_mis", 2'b10, 1'b0, 32'h100, 5'd22, 32'hDEADBEEF);
    check("mis_flag_clear", {31'd0, bus.misalign}, 32'd0);
`else
    check("mis_sw_we", {31'd0, bus.mem_we}, 32'd1);
    check("mis_sw_addr", bus.mem_addr, 32'h100);
    @(posedge clk); #1;
    load_and_check("lw_100_mis", 2'b10, 1'b0, 32'h100, 5'd22, 32'h0BADF00D);
    load_and_check("lh_203_forced", 2'b01, 1'b0, 32'h203, 5'd23, 32'hFFFF8000);
`endif

    req(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
